// File: rtl/cu_pkg.sv
// Shared constants and types for the control-unit step sequencer.
package cu_pkg;

  localparam int unsigned CU_N        = 6;
  localparam int unsigned CU_STATES   = 40;
  localparam int unsigned FETCH_STATE = 0;

  typedef logic [CU_N-1:0] state_idx_t;

endpackage : cu_pkg

// File: rtl/cu_onehot_decoder.sv
// One-hot decode of the step counter into the CPU state vector.
module cu_onehot_decoder #(
  parameter int unsigned N      = 6,
  parameter int unsigned STATES = 40
) (
  input  logic [N-1:0]      counter_value,
  output logic [STATES-1:0] CPU_state
);

  assign CPU_state = STATES'(1) << counter_value;

endmodule : cu_onehot_decoder

// File: rtl/cu_sequencer.sv
// CPU step sequencer: clr > ld > en > hold, wrap pulse on STATES-1 -> 0.
// Define CU_SEQ_LD_TRAP_EN to trap out-of-range jumps to fetch with a sticky ld_err.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int unsigned N      = CU_N,
  parameter int unsigned STATES = CU_STATES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              ld,
  input  logic [N-1:0]      ld_value,
  output logic [N-1:0]      counter_value,
  output logic [STATES-1:0] CPU_state,
  output logic              wrap,
  output logic              ld_err
);

  localparam int unsigned NW     = N + 1;
  localparam logic [N:0]  STATES_W = NW'(STATES);
  localparam logic [N-1:0] LAST  = N'(STATES - 1);
  localparam logic [N-1:0] FETCH = N'(FETCH_STATE);

  if (STATES < 2 || STATES > (1 << N)) begin : g_bad_params
    $error("cu_sequencer: STATES must satisfy 2 <= STATES <= 2**N");
  end

  logic [N-1:0] counter_d;
  logic         wrap_d;
  logic         ld_legal;
  logic         err_d;

  assign ld_legal = ({1'b0, ld_value} < STATES_W);

  // Next-state selection in priority order
  always_comb begin
    counter_d = counter_value;
    wrap_d    = 1'b0;
    err_d     = ld_err;
    if (clr) begin
      counter_d = FETCH;
    end else if (ld) begin
      if (ld_legal) begin
        counter_d = ld_value;
      end else begin
`ifdef CU_SEQ_LD_TRAP_EN
        counter_d = FETCH;
        err_d     = 1'b1;
`endif
      end
    end else if (en) begin
      if (counter_value == LAST) begin
        counter_d = FETCH;
        wrap_d    = 1'b1;
      end else begin
        counter_d = counter_value + N'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_value <= FETCH;
      wrap          <= 1'b0;
    end else begin
      counter_value <= counter_d;
      wrap          <= wrap_d;
    end
  end

`ifdef CU_SEQ_LD_TRAP_EN
  // Sticky illegal-jump flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_err <= 1'b0;
    end else begin
      ld_err <= err_d;
    end
  end
`else
  assign ld_err = 1'b0;
`endif

  cu_onehot_decoder #(
    .N      (N),
    .STATES (STATES)
  ) u_decoder (
    .counter_value (counter_value),
    .CPU_state     (CPU_state)
  );

endmodule : cu_sequencer

// File: tb/tb_cu_sequencer.sv
// Randomized bench for cu_sequencer (40-state and 16-state builds) against an arithmetic model.
module tb_cu_sequencer;

`ifdef CU_SEQ_LD_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic clr = 1'b0;
  logic ld  = 1'b0;
  logic [5:0] lva = '0;
  logic [3:0] lvb = '0;

  logic [5:0]  cva;
  logic [39:0] csa;
  logic        wa, ea;
  logic [3:0]  cvb;
  logic [15:0] csb;
  logic        wb, eb;

  int vectors     = 0;
  int miscompares = 0;
  bit started     = 1'b0;

  int ma = 0, mb = 0;
  bit mwa = 1'b0, mwb = 1'b0, mea = 1'b0, meb = 1'b0;

  cu_sequencer #(.N(6), .STATES(40)) dut_a (
    .clk (clk), .rst (rst), .en (en), .clr (clr), .ld (ld), .ld_value (lva),
    .counter_value (cva), .CPU_state (csa), .wrap (wa), .ld_err (ea)
  );

  cu_sequencer #(.N(4), .STATES(16)) dut_b (
    .clk (clk), .rst (rst), .en (en), .clr (clr), .ld (ld), .ld_value (lvb),
    .counter_value (cvb), .CPU_state (csb), .wrap (wb), .ld_err (eb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one clock of the sequencer expressed as plain integer arithmetic
  task automatic model_next(input int s, input int ldv, inout int cnt, inout bit w, inout bit err);
    w = 1'b0;
    if (clr) begin
      cnt = 0;
    end else if (ld) begin
      if (ldv < s) cnt = ldv;
      else if (TRAP) begin
        cnt = 0;
        err = 1'b1;
      end
    end else if (en) begin
      w   = (cnt == s - 1);
      cnt = (cnt + 1) % s;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma = 0; mb = 0; mwa = 1'b0; mwb = 1'b0; mea = 1'b0; meb = 1'b0;
    end else begin
      model_next(40, int'(lva), ma, mwa, mea);
      model_next(16, int'(lvb), mb, mwb, meb);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("cnt_a",    64'(cva), 64'(ma));
      chk("onehot_a", 64'(csa), 64'(1) << ma);
      chk("wrap_a",   64'(wa),  64'(mwa));
      chk("err_a",    64'(ea),  64'(mea));
      chk("cnt_b",    64'(cvb), 64'(mb));
      chk("onehot_b", 64'(csb), 64'(1) << mb);
      chk("wrap_b",   64'(wb),  64'(mwb));
      chk("err_b",    64'(eb),  64'(meb));
    end
  end

  task automatic cyc(input bit e, input bit c, input bit l, input logic [5:0] va, input logic [3:0] vb);
    en = e; clr = c; ld = l; lva = va; lvb = vb;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst = 1'b1;
    started = 1'b1;
    #1;
    chk("lit_rst_cnt",    64'(cva), 64'd0);
    chk("lit_rst_onehot", 64'(csa), 64'h1);
    chk("lit_rst_wrap",   64'(wa),  64'd0);
    chk("lit_rst_err",    64'(ea),  64'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Free-running count across the wrap
    for (int i = 0; i < 45; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 6'd0, 4'd0);
      if (i == 15) begin
        chk("lit_b_wrap_cnt", 64'(cvb), 64'd0);
        chk("lit_b_wrap",     64'(wb),  64'd1);
      end
      if (i == 38) chk("lit_a_39", 64'(cva), 64'd39);
      if (i == 39) begin
        chk("lit_a_wrap_cnt", 64'(cva), 64'd0);
        chk("lit_a_wrap",     64'(wa),  64'd1);
      end
      if (i == 40) chk("lit_a_wrap_gone", 64'(wa), 64'd0);
    end
    chk("lit_a_after45", 64'(cva), 64'd5);
    chk("lit_b_after45", 64'(cvb), 64'd13);

    // Asynchronous reset mid-count, then reset held against active inputs
    cyc(1'b0, 1'b0, 1'b1, 6'd17, 4'd9);
    chk("lit_ld17", 64'(cva), 64'd17);
    #1 rst = 1'b1;
    #1;
    chk("lit_async_cnt",    64'(cva), 64'd0);
    chk("lit_async_onehot", 64'(csa), 64'h1);
    cyc(1'b1, 1'b1, 1'b1, 6'd30, 4'd7);
    chk("lit_rst_hold", 64'(cva), 64'd0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, 6'd30, 4'd7);
    chk("lit_post_rst_ld", 64'(cva), 64'd30);

    // ld beats en, clr beats ld
    cyc(1'b1, 1'b0, 1'b1, 6'd25, 4'd3);
    chk("lit_ld25", 64'(cva), 64'd25);
    cyc(1'b1, 1'b1, 1'b1, 6'd10, 4'd5);
    chk("lit_clr_over_ld", 64'(cva), 64'd0);

    // Illegal jump target
    cyc(1'b0, 1'b0, 1'b1, 6'd12, 4'd0);
    cyc(1'b1, 1'b0, 1'b1, 6'd50, 4'd0);
    chk("lit_illegal_cnt", 64'(cva), TRAP ? 64'd0 : 64'd12);
    chk("lit_illegal_err", 64'(ea),  TRAP ? 64'd1 : 64'd0);
    cyc(1'b0, 1'b1, 1'b0, 6'd0, 4'd0);
    chk("lit_err_sticky", 64'(ea), TRAP ? 64'd1 : 64'd0);

    // Hold at the last state, then wrap
    cyc(1'b0, 1'b0, 1'b1, 6'd39, 4'd15);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 6'd0, 4'd0);
    chk("lit_hold39",      64'(cva), 64'd39);
    chk("lit_hold39_wrap", 64'(wa),  64'd0);
    cyc(1'b1, 1'b0, 1'b0, 6'd0, 4'd0);
    chk("lit_wrap_after_hold", 64'(wa), 64'd1);
    chk("lit_wrap_cnt0",       64'(cva), 64'd0);

    // A jump to 0 from the last state is not a wrap
    cyc(1'b0, 1'b0, 1'b1, 6'd39, 4'd15);
    cyc(1'b1, 1'b0, 1'b1, 6'd0, 4'd0);
    chk("lit_ld0_nowrap", 64'(wa), 64'd0);

    #1 rst = 1'b1;
    #1 rst = 1'b0;
    chk("lit_err_cleared", 64'(ea), 64'd0);

    // Random traffic with occasional asynchronous reset pulses
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 8) == 0,
          6'($urandom), 4'($urandom));
      if (($urandom % 200) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_cu_sequencer

// File: doc/cu_sequencer.md
CU_SEQUENCER -- requirements
Module: cu_sequencer

Interface
REQ-001 Parameter N, default 6: step-counter width in bits.
REQ-002 Parameter STATES, default 40: number of CPU states (one-hot width); SHALL satisfy 2 <= STATES <= 2**N, elaboration error otherwise.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 en  in  1  advance one state per cycle when high.
REQ-006 clr  in  1  synchronous return to state 0 (fetch).
REQ-007 ld  in  1  synchronous jump request.
REQ-008 ld_value  in  N  jump target state index.
REQ-009 counter_value  out  N  registered current state index.
REQ-010 CPU_state  out  STATES  one-hot decode of counter_value.
REQ-011 wrap  out  1  registered one-cycle pulse on wrap from STATES-1 to 0.
REQ-012 ld_err  out  1  sticky illegal-jump flag (macro-dependent, REQ-027/028).

Function
REQ-013 Per-cycle priority SHALL be clr > ld > en > hold.
REQ-014 clr=1: counter_value <= 0 next edge; wrap <= 0.
REQ-015 ld=1, clr=0, legal target (ld_value < STATES): counter_value <= ld_value next edge; en ignored that cycle.
REQ-016 en=1, clr=0, ld=0, counter_value < STATES-1: counter_value <= counter_value+1.
REQ-017 en=1, clr=0, ld=0, counter_value == STATES-1: counter_value <= 0 and wrap <= 1 for exactly that next cycle.
REQ-018 wrap SHALL be 0 in every cycle not covered by REQ-017, including ld to 0 and clr.
REQ-019 en=0, clr=0, ld=0: counter_value held; wrap <= 0.
REQ-020 CPU_state SHALL equal 1 << counter_value combinationally from the register, zero added latency; exactly one bit high at all times outside reset.
REQ-021 counter_value SHALL never hold a value >= STATES.
REQ-022 Latency: any input change visible on counter_value/CPU_state after exactly one rising edge.

Reset
REQ-023 rst high SHALL immediately (no clock) force counter_value=0, CPU_state=1 (bit 0), wrap=0, ld_err=0.
REQ-024 rst asserted mid-sequence or coincident with clr/ld/en SHALL override all; first edge after release evaluates inputs normally.
REQ-025 ld_err cleared only by rst.

Configuration
REQ-026 Macro CU_SEQ_LD_TRAP_EN selects illegal-jump handling (ld=1, clr=0, ld_value >= STATES).
REQ-027 Defined: illegal jump forces counter_value <= 0 and sets ld_err=1 (sticky).
REQ-028 Undefined: illegal jump ignored, counter_value held (en ignored that cycle), ld_err tied 0.

Structure
REQ-029 Shared package cu_pkg SHALL hold default N, default STATES, FETCH_STATE=0 constant and the state-index typedef (logic [N-1:0]).
REQ-030 One sub-module cu_onehot_decoder (parameters N, STATES; counter_value in, CPU_state out) SHALL implement REQ-020; cu_sequencer instantiates it once.

Verification
REQ-031 rst=1 mid-count at state 17, no clock edge -> counter_value=0, CPU_state=40'h1 immediately.
REQ-032 en=1 for 45 cycles from 0 -> counter_value 0..39 then 0..4; wrap high only in cycle after 39->0; CPU_state==1<<counter_value every cycle.
REQ-033 ld=1, ld_value=25, en=1 same cycle -> next counter_value=25 (not 1); then clr=1, ld=1, ld_value=10 -> next counter_value=0.
REQ-034 ld=1, ld_value=50 at state 12 -> with CU_SEQ_LD_TRAP_EN: counter_value=0, ld_err=1 and stays 1; without: counter_value=12, ld_err=0.
REQ-035 en=0 for 5 cycles at state 39 -> held at 39, wrap=0; then en=1 -> 0 with wrap pulse.
REQ-036 Re-run REQ-032 with N=4, STATES=16 -> full-range wrap 15->0 with wrap pulse, no illegal targets possible.
